// File: rtl/exe_pkg.sv
// Shared constants for the execute/forwarding stage.
//   FWD_SEL_W       : width of the forwarding-select fields (0 = latched register, k = source k-1)
//   mem_size_e      : memory access size encodings (byte / half / word)
//   addr_misaligned : true when an access of the given size is not naturally aligned
package exe_pkg;

  localparam int FWD_SEL_W = 3;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2,
    MEM_RSVD = 2'd3
  } mem_size_e;

  // Only the two low address bits matter for natural alignment up to a word.
  function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (mem_size_e'(size))
      MEM_WORD: mis = (addr_lo != 2'b00);
      MEM_HALF: mis = addr_lo[0];
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/exe_fwd_stage_if.sv
// Bundle of all handshake, instruction, forwarding and result signals of the
// execute/forwarding stage.
//   slave  : the stage itself (consumes in_*/fwd_*/flush/out_ready, drives in_ready and out_*)
//   master : the environment driving the stage
interface exe_fwd_stage_if #(
  parameter int DW   = 32,
  parameter int NSRC = 2,
  parameter int CW   = 32
) ();
  import exe_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_pc;
  logic [DW-1:0]        in_rs;
  logic [DW-1:0]        in_rt;
  logic [DW-1:0]        in_imm;
  logic [CW-1:0]        in_ctrl;
  logic                 in_mem_rd;
  logic                 in_mem_wr;
  logic [1:0]           in_mem_size;
  logic [NSRC*DW-1:0]   fwd_data;
  logic [FWD_SEL_W-1:0] fwd_sel_a;
  logic [FWD_SEL_W-1:0] fwd_sel_b;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_pc;
  logic [DW-1:0]        out_imm;
  logic [CW-1:0]        out_ctrl;
  logic [DW-1:0]        out_a;
  logic [DW-1:0]        out_b;
  logic [DW-1:0]        out_eaddr;
  logic                 out_adel;
  logic                 out_ades;

  modport slave (
    input  in_valid, in_pc, in_rs, in_rt, in_imm, in_ctrl,
    input  in_mem_rd, in_mem_wr, in_mem_size,
    input  fwd_data, fwd_sel_a, fwd_sel_b, flush, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_ctrl,
    output out_a, out_b, out_eaddr, out_adel, out_ades
  );

  modport master (
    output in_valid, in_pc, in_rs, in_rt, in_imm, in_ctrl,
    output in_mem_rd, in_mem_wr, in_mem_size,
    output fwd_data, fwd_sel_a, fwd_sel_b, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_ctrl,
    input  out_a, out_b, out_eaddr, out_adel, out_ades
  );

endinterface

// File: rtl/exe_opnd_hold.sv
// One operand path: forwarding mux plus a hold register that freezes the
// forwarded value once a stall begins, so the operand survives the producer
// moving on while the instruction waits downstream.
//   i_reg_val  : latched register operand (used when select is 0 or out of range)
//   i_fwd_data : all forwarding sources, source k at [k*DW +: DW]
//   i_fwd_sel  : 0 = register value, k = source k-1
//   i_stall    : stage holds a valid instruction that is not being accepted
//   i_clear    : downstream acceptance or flush; drops the hold
//   o_opnd     : resolved operand
//   o_hold     : hold flag
module exe_opnd_hold import exe_pkg::*; #(
  parameter int DW   = 32,
  parameter int NSRC = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [DW-1:0]        i_reg_val,
  input  logic [NSRC*DW-1:0]   i_fwd_data,
  input  logic [FWD_SEL_W-1:0] i_fwd_sel,
  input  logic                 i_stall,
  input  logic                 i_clear,
  output logic [DW-1:0]        o_opnd,
  output logic                 o_hold
);

  logic [DW-1:0] w_fwd_val;
  logic          w_fwd_hit;
  logic [DW-1:0] r_hold_val;
  logic          r_hold;

  // Forwarding mux; a select above NSRC matches no source and falls back to the register value.
  always_comb begin
    w_fwd_val = {DW{1'b0}};
    w_fwd_hit = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      w_fwd_val = w_fwd_val | ({DW{i_fwd_sel == FWD_SEL_W'(k + 1)}} & i_fwd_data[k*DW +: DW]);
      w_fwd_hit = w_fwd_hit | (i_fwd_sel == FWD_SEL_W'(k + 1));
    end
  end

  // Hold register: capture the forwarded value on the first stalled edge, drop it on clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold     <= 1'b0;
      r_hold_val <= {DW{1'b0}};
    end else if (i_clear) begin
      r_hold     <= 1'b0;
      r_hold_val <= {DW{1'b0}};
    end else if (i_stall && !r_hold && w_fwd_hit) begin
      r_hold     <= 1'b1;
      r_hold_val <= w_fwd_val;
    end else begin
      r_hold     <= r_hold;
      r_hold_val <= r_hold_val;
    end
  end

  assign o_opnd = r_hold ? r_hold_val : (w_fwd_hit ? w_fwd_val : i_reg_val);
  assign o_hold = r_hold;

endmodule

// File: rtl/exe_fwd_stage.sv
// Execute-stage pipeline register with operand forwarding and stall-safe
// operand holding; produces the effective address and optional load/store
// misalignment flags.
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   io     : exe_fwd_stage_if.slave (handshakes, instruction fields, forwarding, results)
// Build option: define EXE_ALIGN_CHECK_EN to compile the misalignment checker;
// otherwise out_adel/out_ades are tied low.
module exe_fwd_stage import exe_pkg::*; #(
  parameter int DW   = 32,
  parameter int NSRC = 2,
  parameter int CW   = 32
) (
  input logic            clk,
  input logic            resetn,
  exe_fwd_stage_if.slave io
);

  logic          r_out_valid;
  logic [DW-1:0] r_pc;
  logic [DW-1:0] r_rs;
  logic [DW-1:0] r_rt;
  logic [DW-1:0] r_imm;
  logic [CW-1:0] r_ctrl;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic [1:0]    r_mem_size;

  logic          w_in_ready;
  logic          w_xfer;
  logic          w_accept;
  logic          w_stall;
  logic          w_clear;
  logic [DW-1:0] w_opnd_a;
  logic [DW-1:0] w_opnd_b;
  logic          w_hold_a;
  logic          w_hold_b;
  logic [DW-1:0] w_eaddr;

  assign w_in_ready = !r_out_valid || io.out_ready;
  assign w_xfer     = io.in_valid && w_in_ready;
  assign w_accept   = r_out_valid && io.out_ready;
  assign w_stall    = r_out_valid && !io.out_ready;
  assign w_clear    = w_accept || io.flush;

  // Stage register: flush kills (and wins over a transfer), a transfer loads, an acceptance drains.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_pc        <= {DW{1'b0}};
      r_rs        <= {DW{1'b0}};
      r_rt        <= {DW{1'b0}};
      r_imm       <= {DW{1'b0}};
      r_ctrl      <= {CW{1'b0}};
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_size  <= 2'd0;
    end else if (io.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_pc        <= io.in_pc;
      r_rs        <= io.in_rs;
      r_rt        <= io.in_rt;
      r_imm       <= io.in_imm;
      r_ctrl      <= io.in_ctrl;
      r_mem_rd    <= io.in_mem_rd;
      r_mem_wr    <= io.in_mem_wr;
      r_mem_size  <= io.in_mem_size;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  exe_opnd_hold #(.DW(DW), .NSRC(NSRC)) u_opnd_a (
    .clk        (clk),
    .resetn     (resetn),
    .i_reg_val  (r_rs),
    .i_fwd_data (io.fwd_data),
    .i_fwd_sel  (io.fwd_sel_a),
    .i_stall    (w_stall),
    .i_clear    (w_clear),
    .o_opnd     (w_opnd_a),
    .o_hold     (w_hold_a)
  );

  exe_opnd_hold #(.DW(DW), .NSRC(NSRC)) u_opnd_b (
    .clk        (clk),
    .resetn     (resetn),
    .i_reg_val  (r_rt),
    .i_fwd_data (io.fwd_data),
    .i_fwd_sel  (io.fwd_sel_b),
    .i_stall    (w_stall),
    .i_clear    (w_clear),
    .o_opnd     (w_opnd_b),
    .o_hold     (w_hold_b)
  );

  // The hold flags are internal state; exposed here only for debug visibility.
  logic w_unused_holds;
  assign w_unused_holds = w_hold_a ^ w_hold_b;

  assign w_eaddr = w_opnd_a + r_imm;

  assign io.in_ready  = w_in_ready;
  assign io.out_valid = r_out_valid;
  assign io.out_pc    = r_pc;
  assign io.out_imm   = r_imm;
  assign io.out_ctrl  = r_ctrl;
  // Operands and address read as zero when the stage is empty (including during reset).
  assign io.out_a     = r_out_valid ? w_opnd_a : {DW{1'b0}};
  assign io.out_b     = r_out_valid ? w_opnd_b : {DW{1'b0}};
  assign io.out_eaddr = r_out_valid ? w_eaddr  : {DW{1'b0}};

`ifdef EXE_ALIGN_CHECK_EN
  assign io.out_adel = r_out_valid && r_mem_rd && addr_misaligned(r_mem_size, w_eaddr[1:0]);
  assign io.out_ades = r_out_valid && r_mem_wr && addr_misaligned(r_mem_size, w_eaddr[1:0]);
`else
  // Memory-op fields are still latched so a downstream stage can rely on them later.
  logic w_unused_mem;
  assign w_unused_mem = ^{r_mem_rd, r_mem_wr, r_mem_size};
  assign io.out_adel  = 1'b0;
  assign io.out_ades  = 1'b0;
`endif

endmodule

// File: tb/tb_exe_fwd_stage.sv
module tb_exe_fwd_stage;
  import exe_pkg::*;

  localparam int DW   = 32;
  localparam int NSRC = 2;
  localparam int CW   = 32;

`ifdef EXE_ALIGN_CHECK_EN
  localparam logic ALIGN_ON = 1'b1;
`else
  localparam logic ALIGN_ON = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] eaddr;
    logic [CW-1:0] ctrl;
  } exp_t;

  logic clk;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  exp_t e;

  logic [31:0] al_rs  [7];
  logic [31:0] al_imm [7];
  logic        al_rd  [7];
  logic [1:0]  al_sz  [7];
  logic        al_mis [7];

  exe_fwd_stage_if #(.DW(DW), .NSRC(NSRC), .CW(CW)) bus ();

  exe_fwd_stage #(.DW(DW), .NSRC(NSRC), .CW(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.in_valid    = 1'b0;
    bus.in_pc       = 32'h0;
    bus.in_rs       = 32'h0;
    bus.in_rt       = 32'h0;
    bus.in_imm      = 32'h0;
    bus.in_ctrl     = 32'h0;
    bus.in_mem_rd   = 1'b0;
    bus.in_mem_wr   = 1'b0;
    bus.in_mem_size = 2'd0;
    bus.fwd_data    = 64'h0;
    bus.fwd_sel_a   = 3'd0;
    bus.fwd_sel_b   = 3'd0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b1;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] imm, input logic rd, input logic wr,
                             input logic [1:0] size);
    bus.in_valid    = 1'b1;
    bus.in_pc       = pc;
    bus.in_rs       = rs;
    bus.in_rt       = rt;
    bus.in_imm      = imm;
    bus.in_ctrl     = ~pc;
    bus.in_mem_rd   = rd;
    bus.in_mem_wr   = wr;
    bus.in_mem_size = size;
  endtask

  task automatic sb_push(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eaddr);
    exp_t x;
    x.pc = pc; x.a = a; x.b = b; x.eaddr = eaddr; x.ctrl = ~pc;
    sb_q.push_back(x);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    set_idle();
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h1111;
    bus.fwd_sel_a = 3'd1;
    bus.fwd_data  = {32'hCAFE0001, 32'hCAFE0000};
    repeat (2) tick();
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_adel, bus.out_ades} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/ready/adel/ades=%b want 0100",
               {bus.out_valid, bus.in_ready, bus.out_adel, bus.out_ades});
    end
    n_checks++;
    if ({bus.out_pc, bus.out_a, bus.out_b, bus.out_eaddr} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: got pc/a/b/eaddr=%h want 0",
               {bus.out_pc, bus.out_a, bus.out_b, bus.out_eaddr});
    end
    @(negedge clk);
    resetn = 1'b1;
    set_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    drive_instr(32'h100, 32'h5, 32'h6, 32'h4, 1'b0, 1'b0, 2'd2);
    sb_push(32'h100, 32'h5, 32'h6, 32'h9);
    tick();
    drive_instr(32'h104, 32'h7, 32'h8, 32'h8, 1'b0, 1'b0, 2'd2);
    sb_push(32'h104, 32'h7, 32'h8, 32'hF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b2b_out%0d: scoreboard empty", i);
      end else begin
        e = sb_q.pop_front();
        n_checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_a, bus.out_b, bus.out_eaddr, bus.out_ctrl} !==
            {1'b1, e.pc, e.a, e.b, e.eaddr, e.ctrl}) begin
          n_fail++;
          $display("FAIL b2b_out%0d: got v/pc/a/b/ea=%b/%h/%h/%h/%h want 1/%h/%h/%h/%h", i,
                   bus.out_valid, bus.out_pc, bus.out_a, bus.out_b, bus.out_eaddr,
                   e.pc, e.a, e.b, e.eaddr);
        end
      end
      tick();
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got out_valid=%b want 0", bus.out_valid);
    end
    tick();
  endtask

  task automatic test_stall_capture();
    drive_instr(32'h200, 32'h11, 32'h22, 32'h10, 1'b0, 1'b0, 2'd2);
    sb_push(32'h200, 32'h1234, 32'h22, 32'h1244);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.fwd_sel_a = 3'd2;
    bus.fwd_data  = {32'h1234, 32'h0};
    @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.out_a} !== {1'b0, 32'h1234}) begin
      n_fail++;
      $display("FAIL stall_live: got in_ready/out_a=%b/%h want 0/00001234", bus.in_ready, bus.out_a);
    end
    tick();
    bus.fwd_data = {32'hFFFF, 32'h0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_a !== 32'h1234) begin
        n_fail++;
        $display("FAIL stall_held%0d: got out_a=%h want 00001234", i, bus.out_a);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL stall_accept: scoreboard empty");
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if ({bus.out_pc, bus.out_a, bus.out_b, bus.out_eaddr} !== {e.pc, e.a, e.b, e.eaddr}) begin
        n_fail++;
        $display("FAIL stall_accept: got pc/a/b/ea=%h/%h/%h/%h want %h/%h/%h/%h",
                 bus.out_pc, bus.out_a, bus.out_b, bus.out_eaddr, e.pc, e.a, e.b, e.eaddr);
      end
    end
    tick();
    drive_instr(32'h204, 32'h33, 32'h44, 32'h0, 1'b0, 1'b0, 2'd2);
    sb_push(32'h204, 32'hFFFF, 32'h44, 32'hFFFF);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL stall_released: scoreboard empty");
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if ({bus.out_valid, bus.out_pc, bus.out_a, bus.out_b} !== {1'b1, e.pc, e.a, e.b}) begin
        n_fail++;
        $display("FAIL stall_released: got v/pc/a/b=%b/%h/%h/%h want 1/%h/%h/%h",
                 bus.out_valid, bus.out_pc, bus.out_a, bus.out_b, e.pc, e.a, e.b);
      end
    end
    tick();
    set_idle();
  endtask

  task automatic test_dual_hold();
    drive_instr(32'h300, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 2'd2);
    sb_push(32'h300, 32'hA, 32'hB, 32'hA);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.fwd_sel_a = 3'd1;
    bus.fwd_sel_b = 3'd2;
    bus.fwd_data  = {32'hB, 32'hA};
    tick();
    bus.fwd_data  = {32'h66, 32'h55};
    @(negedge clk);
    n_checks++;
    if ({bus.out_a, bus.out_b} !== {32'hA, 32'hB}) begin
      n_fail++;
      $display("FAIL dual_held: got a/b=%h/%h want 0000000a/0000000b", bus.out_a, bus.out_b);
    end
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL dual_accept: scoreboard empty");
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if ({bus.out_pc, bus.out_a, bus.out_b, bus.out_eaddr} !== {e.pc, e.a, e.b, e.eaddr}) begin
        n_fail++;
        $display("FAIL dual_accept: got pc/a/b/ea=%h/%h/%h/%h want %h/%h/%h/%h",
                 bus.out_pc, bus.out_a, bus.out_b, bus.out_eaddr, e.pc, e.a, e.b, e.eaddr);
      end
    end
    tick();
    drive_instr(32'h304, 32'h3, 32'h4, 32'h0, 1'b0, 1'b0, 2'd2);
    sb_push(32'h304, 32'h55, 32'h66, 32'h55);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL dual_cleared: scoreboard empty");
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if ({bus.out_pc, bus.out_a, bus.out_b, bus.out_eaddr} !== {e.pc, e.a, e.b, e.eaddr}) begin
        n_fail++;
        $display("FAIL dual_cleared: got pc/a/b/ea=%h/%h/%h/%h want %h/%h/%h/%h",
                 bus.out_pc, bus.out_a, bus.out_b, bus.out_eaddr, e.pc, e.a, e.b, e.eaddr);
      end
    end
    tick();
    set_idle();
  endtask

  task automatic test_sel_range();
    drive_instr(32'h400, 32'h77, 32'h88, 32'h1, 1'b0, 1'b0, 2'd2);
    bus.fwd_sel_a = 3'd7;
    bus.fwd_sel_b = 3'd3;
    bus.fwd_data  = {32'hAAAA, 32'hBBBB};
    sb_push(32'h400, 32'h77, 32'h88, 32'h78);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    bus.fwd_data  = {32'hCCCC, 32'hDDDD};
    @(negedge clk);
    n_checks++;
    if ({bus.out_a, bus.out_b} !== {32'h77, 32'h88}) begin
      n_fail++;
      $display("FAIL sel_range_stall: got a/b=%h/%h want 00000077/00000088", bus.out_a, bus.out_b);
    end
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL sel_range_accept: scoreboard empty");
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if ({bus.out_pc, bus.out_a, bus.out_b, bus.out_eaddr} !== {e.pc, e.a, e.b, e.eaddr}) begin
        n_fail++;
        $display("FAIL sel_range_accept: got pc/a/b/ea=%h/%h/%h/%h want %h/%h/%h/%h",
                 bus.out_pc, bus.out_a, bus.out_b, bus.out_eaddr, e.pc, e.a, e.b, e.eaddr);
      end
    end
    tick();
    set_idle();
  endtask

  task automatic test_flush();
    drive_instr(32'h500, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 2'd2);
    bus.flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_in_ready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_vs_xfer: got out_valid=%b want 0", bus.out_valid);
    end
    tick();
    // Flush a stalled instruction that has a captured operand.
    drive_instr(32'h504, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 2'd2);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.fwd_sel_a = 3'd1;
    bus.fwd_data  = {32'h0, 32'hEE};
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.fwd_sel_a = 3'd0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stalled: got out_valid=%b want 0", bus.out_valid);
    end
    tick();
    drive_instr(32'h508, 32'h5, 32'h6, 32'h0, 1'b0, 1'b0, 2'd2);
    sb_push(32'h508, 32'h5, 32'h6, 32'h5);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL flush_no_hold: scoreboard empty");
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if ({bus.out_valid, bus.out_pc, bus.out_a, bus.out_b} !== {1'b1, e.pc, e.a, e.b}) begin
        n_fail++;
        $display("FAIL flush_no_hold: got v/pc/a/b=%b/%h/%h/%h want 1/%h/%h/%h",
                 bus.out_valid, bus.out_pc, bus.out_a, bus.out_b, e.pc, e.a, e.b);
      end
    end
    tick();
    set_idle();
  endtask

  task automatic test_align();
    al_rs  = '{32'h1000, 32'h1001, 32'h1004, 32'h1001, 32'h1000, 32'h0FFF, 32'hFFFFFFFF};
    al_imm = '{32'h2,    32'h0,    32'h0,    32'h2,    32'h2,    32'h1,    32'h3};
    al_rd  = '{1'b1,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0,     1'b1};
    al_sz  = '{2'd2,     2'd1,     2'd2,     2'd0,     2'd1,     2'd2,     2'd2};
    al_mis = '{1'b1,     1'b1,     1'b0,     1'b0,     1'b0,     1'b0,     1'b1};
    for (int i = 0; i < 7; i++) begin
      drive_instr(32'h700 + 32'(i * 4), al_rs[i], 32'h0, al_imm[i], al_rd[i], !al_rd[i], al_sz[i]);
      sb_push(32'h700 + 32'(i * 4), al_rs[i], 32'h0, al_rs[i] + al_imm[i]);
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL align%0d_addr: scoreboard empty", i);
      end else begin
        e = sb_q.pop_front();
        n_checks++;
        if ({bus.out_pc, bus.out_a, bus.out_eaddr} !== {e.pc, e.a, e.eaddr}) begin
          n_fail++;
          $display("FAIL align%0d_addr: got pc/a/ea=%h/%h/%h want %h/%h/%h", i,
                   bus.out_pc, bus.out_a, bus.out_eaddr, e.pc, e.a, e.eaddr);
        end
      end
      n_checks++;
      if ({bus.out_adel, bus.out_ades} !==
          {al_mis[i] & al_rd[i] & ALIGN_ON, al_mis[i] & !al_rd[i] & ALIGN_ON}) begin
        n_fail++;
        $display("FAIL align%0d_flags: got adel/ades=%b%b want %b%b", i, bus.out_adel, bus.out_ades,
                 al_mis[i] & al_rd[i] & ALIGN_ON, al_mis[i] & !al_rd[i] & ALIGN_ON);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_reset_mid_stall();
    drive_instr(32'h600, 32'h1, 32'h2, 32'h4, 1'b1, 1'b0, 2'd2);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.fwd_sel_a = 3'd1;
    bus.fwd_data  = {32'h0, 32'hDEAD};
    tick();
    bus.fwd_data  = {32'h0, 32'hBEEF};
    @(negedge clk);
    n_checks++;
    if (bus.out_a !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL rst_pre_held: got out_a=%h want 0000dead", bus.out_a);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_adel, bus.out_ades} !== 4'b0100) begin
      n_fail++;
      $display("FAIL rst_mid_flags: got valid/ready/adel/ades=%b want 0100",
               {bus.out_valid, bus.in_ready, bus.out_adel, bus.out_ades});
    end
    n_checks++;
    if ({bus.out_pc, bus.out_a, bus.out_b, bus.out_eaddr} !== 128'h0) begin
      n_fail++;
      $display("FAIL rst_mid_data: got pc/a/b/ea=%h want 0",
               {bus.out_pc, bus.out_a, bus.out_b, bus.out_eaddr});
    end
    sb_q.delete();
    tick();
    resetn = 1'b1;
    set_idle();
    drive_instr(32'h604, 32'h44, 32'h55, 32'h0, 1'b0, 1'b0, 2'd2);
    sb_push(32'h604, 32'h44, 32'h55, 32'h44);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.out_a !== 32'h44) begin
      n_fail++;
      $display("FAIL rst_no_hold_stall: got out_a=%h want 00000044", bus.out_a);
    end
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL rst_after: scoreboard empty");
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if ({bus.out_valid, bus.out_pc, bus.out_a, bus.out_b} !== {1'b1, e.pc, e.a, e.b}) begin
        n_fail++;
        $display("FAIL rst_after: got v/pc/a/b=%b/%h/%h/%h want 1/%h/%h/%h",
                 bus.out_valid, bus.out_pc, bus.out_a, bus.out_b, e.pc, e.a, e.b);
      end
    end
    tick();
    set_idle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall_capture();
    test_dual_hold();
    test_sel_range();
    test_flush();
    test_align();
    test_reset_mid_stall();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_fwd_stage.md
EXE_FWD_STAGE -- requirements
Module: exe_fwd_stage

Interface
REQ-001 SHALL have parameter DW, default 32: datapath width.
REQ-002 SHALL have parameter NSRC, default 2: number of forwarding sources; must be 1..7.
REQ-003 SHALL have parameter CW, default 32: opaque control sideband width.
REQ-004 SHALL have clk  input  1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have resetn  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have in_valid, in_ready  input/output  1 each: upstream handshake.
REQ-007 SHALL have in_pc, in_rs, in_rt, in_imm  input  DW each: instruction PC, register operands and extended immediate.
REQ-008 SHALL have in_ctrl  input  CW: sideband, passed through unmodified.
REQ-009 SHALL have in_mem_rd, in_mem_wr  input  1 each, and in_mem_size  input  2: memory op, with size 0=byte, 1=half, 2=word.
REQ-010 SHALL have fwd_data  input  NSRC*DW: forwarding values; source k occupies bits [k*DW +: DW].
REQ-011 SHALL have fwd_sel_a, fwd_sel_b  input  3 each: 0 selects the latched register value; k selects source k-1.
REQ-012 SHALL have flush  input  1: synchronous kill of the held instruction.
REQ-013 SHALL have out_valid, out_ready  output/input  1 each: downstream handshake.
REQ-014 SHALL have out_pc, out_imm  output  DW each, and out_ctrl  output  CW: latched values.
REQ-015 SHALL have out_a, out_b  output  DW each: resolved operands after forwarding.
REQ-016 SHALL have out_eaddr  output  DW: effective address out_a + out_imm, modulo 2^DW.
REQ-017 SHALL have out_adel, out_ades  output  1 each: load and store misalignment flags.

Function
REQ-018 SHALL compute in_ready = !out_valid || out_ready.
REQ-019 SHALL treat a transfer as in_valid && in_ready; on a transfer, latch all in_* fields and set out_valid.
REQ-020 SHALL clear out_valid when out_valid && out_ready && !in_valid.
REQ-021 SHALL hold all latched fields unchanged while stalled; stalled means out_valid && !out_ready.
REQ-022 SHALL resolve out_a as the hold register when hold_a=1; otherwise the latched in_rs when fwd_sel_a=0; otherwise fwd_data source fwd_sel_a-1. out_b is resolved the same way.
REQ-023 SHALL treat any fwd_sel value above NSRC as 0.
REQ-024 SHALL, while stalled with hold_x=0 and fwd_sel_x!=0, capture the forwarded value into hold register x and set hold_x on the next edge.
REQ-025 SHALL keep the hold for operand A independent of operand B; a stall that forwards on both operands captures both values.
REQ-026 SHALL clear hold_a and hold_b on any downstream acceptance, on flush, or on reset.
REQ-027 SHALL give flush priority over a simultaneous transfer: out_valid clears, holds clear, and in_ready stays combinational per REQ-018.
REQ-028 SHALL drive out_adel, out_ades and out_eaddr as combinational outputs of the resolved operands, qualified by out_valid.

Reset
REQ-029 SHALL clear out_valid, hold_a, hold_b and all latched fields to 0 while resetn=0, regardless of clk.
REQ-030 SHALL present out_a=out_b=out_eaddr=0, out_adel=out_ades=0 and in_ready=1 during reset.
REQ-031 SHALL discard any stall in progress when reset is asserted, with no residual hold after release.

Configuration
REQ-032 SHALL compile the misalignment checker when EXE_ALIGN_CHECK_EN is defined.
REQ-033 SHALL, with EXE_ALIGN_CHECK_EN defined, drive out_adel = out_valid && mem_rd && ((size=2 && eaddr[1:0]!=0) || (size=1 && eaddr[0])).
REQ-034 SHALL, with EXE_ALIGN_CHECK_EN defined, drive out_ades by the same rule using mem_wr.
REQ-035 SHALL, without EXE_ALIGN_CHECK_EN, tie out_adel and out_ades to 0; out_eaddr is still produced.

Structure
REQ-036 SHALL define the mem_size encodings and the fwd_sel width (3) as constants in the shared package exe_pkg.
REQ-037 SHALL implement each operand path (mux, hold register, hold flag) in one sub-module, exe_opnd_hold, instantiated twice.

Verification
REQ-038 SHALL cover back-to-back flow: two transfers with out_ready=1 -> out_valid stays 1 and out_pc changes on consecutive cycles.
REQ-039 SHALL cover stall capture: stall with fwd_sel_a=2 and source 1=0x1234, then source 1 changes to 0xFFFF -> out_a stays 0x1234 until acceptance.
REQ-040 SHALL cover dual hold: stall with fwd_sel_a=1 (0xA) and fwd_sel_b=2 (0xB) -> both values held independently, and both holds cleared after out_ready.
REQ-041 SHALL cover flush versus transfer: flush=1 and in_valid=1 in the same cycle -> out_valid=0 on the next cycle.
REQ-042 SHALL cover alignment with the macro on: load word with out_a=0x1000, imm=2 -> eaddr=0x1002 and out_adel=1; with the macro off -> out_adel=0.
REQ-043 SHALL cover mid-stall reset: assert resetn=0 during a held stall -> all outputs 0 immediately, in_ready=1, and no hold after release.
